// File: rtl/adder_pkg.sv
// Types shared by the pipelined adder and its stage sub-module.
package adder_pkg;

  typedef enum logic {
    ADD_WRAP = 1'b0,
    ADD_SAT  = 1'b1
  } add_mode_e;

endpackage

// File: rtl/adder_stage.sv
// One CHUNK-wide slice of the carry chain plus the stage register that holds the beat.
// Operands and partial result travel whole so each stage only fills in its own chunk.
module adder_stage
  import adder_pkg::*;
#(
  parameter int BITS  = 8,
  parameter int CHUNK = 4,
  parameter int IDX   = 0
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            i_en,
  input  logic            i_valid,
  input  logic [BITS-1:0] i_a,
  input  logic [BITS-1:0] i_b,
  input  logic [BITS-1:0] i_sum,
  input  logic            i_carry,
  input  add_mode_e       i_mode,
  output logic            o_valid,
  output logic [BITS-1:0] o_a,
  output logic [BITS-1:0] o_b,
  output logic [BITS-1:0] o_sum,
  output logic            o_carry,
  output add_mode_e       o_mode
);

  localparam int LSB = IDX * CHUNK;

  logic [CHUNK:0]  w_chunk;
  logic [BITS-1:0] w_sum;

  logic            r_valid;
  logic [BITS-1:0] r_a;
  logic [BITS-1:0] r_b;
  logic [BITS-1:0] r_sum;
  logic            r_carry;
  add_mode_e       r_mode;

  assign w_chunk = {1'b0, i_a[LSB +: CHUNK]} + {1'b0, i_b[LSB +: CHUNK]} + {{CHUNK{1'b0}}, i_carry};

  always_comb begin
    w_sum = i_sum;
    w_sum[LSB +: CHUNK] = w_chunk[CHUNK-1:0];
  end

  // Data only loads with a valid beat, so bubbles leave the last result visible downstream.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_valid <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_mode  <= ADD_WRAP;
    end else if (i_en) begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_a     <= i_a;
        r_b     <= i_b;
        r_sum   <= w_sum;
        r_carry <= w_chunk[CHUNK];
        r_mode  <= i_mode;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_a     = r_a;
  assign o_b     = r_b;
  assign o_sum   = r_sum;
  assign o_carry = r_carry;
  assign o_mode  = r_mode;

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined unsigned adder: STAGES chunked carry stages under one global stall,
// with per-beat wrap/saturate selection applied at the output.
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int BITS   = 8,
  parameter int STAGES = 2
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [BITS-1:0] A,
  input  logic [BITS-1:0] B,
  input  logic            cin,
  input  add_mode_e       mode,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [BITS-1:0] sum,
  output logic            carry
);

  localparam int NSTG  = (STAGES < 1) ? 1 : STAGES;
  localparam int CHUNK = BITS / NSTG;

  if ((STAGES < 1) || ((BITS % NSTG) != 0)) begin : g_param_check
    $error("pipelined_adder: BITS (%0d) must be a multiple of STAGES (%0d), STAGES >= 1", BITS, STAGES);
  end

  logic            w_advance;
  logic            w_valid [0:NSTG];
  logic [BITS-1:0] w_a     [0:NSTG];
  logic [BITS-1:0] w_b     [0:NSTG];
  logic [BITS-1:0] w_sum   [0:NSTG];
  logic            w_carry [0:NSTG];
  add_mode_e       w_mode  [0:NSTG];
  logic            w_unused_ops;

  assign w_valid[0] = in_valid;
  assign w_a[0]     = A;
  assign w_b[0]     = B;
  assign w_sum[0]   = '0;
  assign w_carry[0] = cin;
  assign w_mode[0]  = mode;

  for (genvar gi = 0; gi < NSTG; gi++) begin : g_stage
    adder_stage #(
      .BITS (BITS),
      .CHUNK(CHUNK),
      .IDX  (gi)
    ) u_stage (
      .clock  (clock),
      .reset_n(reset_n),
      .i_en   (w_advance),
      .i_valid(w_valid[gi]),
      .i_a    (w_a[gi]),
      .i_b    (w_b[gi]),
      .i_sum  (w_sum[gi]),
      .i_carry(w_carry[gi]),
      .i_mode (w_mode[gi]),
      .o_valid(w_valid[gi+1]),
      .o_a    (w_a[gi+1]),
      .o_b    (w_b[gi+1]),
      .o_sum  (w_sum[gi+1]),
      .o_carry(w_carry[gi+1]),
      .o_mode (w_mode[gi+1])
    );
  end

  // Operands are fully consumed once the last chunk has been added.
  assign w_unused_ops = ^{w_a[NSTG], w_b[NSTG]};

  assign w_advance = !w_valid[NSTG] || out_ready;
  assign in_ready  = w_advance;
  assign out_valid = w_valid[NSTG];
  assign carry     = w_carry[NSTG];
  assign sum       = ((w_mode[NSTG] == ADD_SAT) && w_carry[NSTG]) ? {BITS{1'b1}} : w_sum[NSTG];

endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder: directed vector table and corner sequences on the 8/2 build,
// then randomized streams with stalls on 8/2, 16/4 and 8/1 against an arithmetic model.
module tb_pipelined_adder;
  import adder_pkg::*;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    add_mode_e  mode;
    logic [7:0] exp_sum;
    logic       exp_carry;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;

  logic        in_valid_s [3];
  logic        out_ready_s[3];
  logic [15:0] a_s        [3];
  logic [15:0] b_s        [3];
  logic        cin_s      [3];
  add_mode_e   mode_s     [3];

  logic        in_ready_s [3];
  logic        out_valid_s[3];
  logic        carry_s    [3];
  logic [15:0] sum_s      [3];

  logic        rdy0, rdy1, rdy2, ov0, ov1, ov2, c0, c1, c2;
  logic [7:0]  sum0, sum2;
  logic [15:0] sum1;

  int          n_vec = 0;
  int          n_err = 0;
  logic [16:0] exp_q[$];
  logic        hold_pend = 1'b0;
  logic [16:0] hold_val;
  int          retired = 0;
  bit          verbose = 1'b1;

  always #5 clk = ~clk;

  pipelined_adder #(.BITS(8), .STAGES(2)) u_dut0 (
    .clock(clk), .reset_n(rst_n), .in_valid(in_valid_s[0]), .in_ready(rdy0),
    .A(a_s[0][7:0]), .B(b_s[0][7:0]), .cin(cin_s[0]), .mode(mode_s[0]),
    .out_valid(ov0), .out_ready(out_ready_s[0]), .sum(sum0), .carry(c0)
  );

  pipelined_adder #(.BITS(16), .STAGES(4)) u_dut1 (
    .clock(clk), .reset_n(rst_n), .in_valid(in_valid_s[1]), .in_ready(rdy1),
    .A(a_s[1]), .B(b_s[1]), .cin(cin_s[1]), .mode(mode_s[1]),
    .out_valid(ov1), .out_ready(out_ready_s[1]), .sum(sum1), .carry(c1)
  );

  pipelined_adder #(.BITS(8), .STAGES(1)) u_dut2 (
    .clock(clk), .reset_n(rst_n), .in_valid(in_valid_s[2]), .in_ready(rdy2),
    .A(a_s[2][7:0]), .B(b_s[2][7:0]), .cin(cin_s[2]), .mode(mode_s[2]),
    .out_valid(ov2), .out_ready(out_ready_s[2]), .sum(sum2), .carry(c2)
  );

  always_comb begin
    in_ready_s[0]  = rdy0;  in_ready_s[1]  = rdy1;  in_ready_s[2]  = rdy2;
    out_valid_s[0] = ov0;   out_valid_s[1] = ov1;   out_valid_s[2] = ov2;
    carry_s[0]     = c0;    carry_s[1]     = c1;    carry_s[2]     = c2;
    sum_s[0]       = {8'h00, sum0};
    sum_s[1]       = sum1;
    sum_s[2]       = {8'h00, sum2};
  end

  function automatic int bits_of(input int idx);
    return (idx == 1) ? 16 : 8;
  endfunction

  // Reference: plain (BITS+1)-wide addition, saturate to all-ones on overflow in SAT mode.
  function automatic logic [16:0] model(input int bits, input logic [15:0] a, input logic [15:0] b,
                                        input logic ci, input add_mode_e m);
    logic [16:0] mask;
    logic [16:0] full;
    logic        co;
    mask = (17'd1 << bits) - 17'd1;
    full = ({1'b0, a} & mask) + ({1'b0, b} & mask) + {16'd0, ci};
    co   = full[bits];
    full = full & mask;
    if (m == ADD_SAT && co) full = mask;
    return {co, full[15:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Called on the falling edge: scores retiring beats, records accepted ones, checks held outputs.
  task automatic sample(input int idx);
    logic [16:0] act;
    logic [16:0] exp;
    act = {carry_s[idx], sum_s[idx]};
    if (hold_pend) begin
      check("hold_valid", {31'd0, out_valid_s[idx]}, 32'd1);
      check("hold_data", {15'd0, act}, {15'd0, hold_val});
      hold_pend = 1'b0;
    end
    if (out_valid_s[idx]) begin
      if (out_ready_s[idx]) begin
        if (exp_q.size() == 0) begin
          check("spurious_out", {31'd0, out_valid_s[idx]}, 32'd0);
        end else begin
          exp = exp_q.pop_front();
          check("result", {15'd0, act}, {15'd0, exp});
          retired++;
          if (verbose)
            $display("cfg%0d beat %0d: sum=0x%0h carry=%0b expected sum=0x%0h carry=%0b",
                     idx, retired, act[15:0], act[16], exp[15:0], exp[16]);
        end
      end else begin
        hold_pend = 1'b1;
        hold_val  = act;
      end
    end
    if (in_valid_s[idx] && in_ready_s[idx])
      exp_q.push_back(model(bits_of(idx), a_s[idx], b_s[idx], cin_s[idx], mode_s[idx]));
  endtask

  // After a beat was accepted, count edges until it reaches the output.
  task automatic wait_result(input int idx, input int exp_lat);
    int lat;
    lat = 0;
    while (lat < 10) begin
      @(posedge clk); #1;
      in_valid_s[idx] = 1'b0;
      a_s[idx] = 16'($urandom);
      b_s[idx] = 16'($urandom);
      @(negedge clk);
      lat++;
      if (out_valid_s[idx]) break;
      sample(idx);
    end
    check("latency", lat, exp_lat);
  endtask

  task automatic run_random(input int idx, input int nbeats);
    int  sent;
    int  cycles;
    bit  acc_last;
    sent = 0; cycles = 0; acc_last = 1'b0;
    retired = 0; hold_pend = 1'b0; exp_q.delete();
    in_valid_s[idx] = 1'b0;
    while (retired < nbeats && cycles < nbeats * 6 + 200) begin
      @(posedge clk); #1;
      cycles++;
      if (!(in_valid_s[idx] && !acc_last)) begin
        a_s[idx]    = 16'($urandom);
        b_s[idx]    = 16'($urandom);
        cin_s[idx]  = 1'($urandom_range(0, 1));
        mode_s[idx] = add_mode_e'($urandom_range(0, 1));
        in_valid_s[idx] = (sent < nbeats) && ($urandom_range(0, 3) != 0);
      end
      out_ready_s[idx] = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc_last = in_valid_s[idx] && in_ready_s[idx];
      sample(idx);
      if (acc_last) sent++;
    end
    check("rand_done", retired, nbeats);
    $display("cfg%0d random stream: %0d beats retired in %0d cycles", idx, retired, cycles);
    @(posedge clk); #1;
    in_valid_s[idx]  = 1'b0;
    out_ready_s[idx] = 1'b1;
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl[10];
    logic [7:0]  bp_a[6];
    logic [7:0]  bp_b[6];
    int          sent;

    tbl[0] = '{8'hF0, 8'h0F, 1'b0, ADD_WRAP, 8'hFF, 1'b0};
    tbl[1] = '{8'h0F, 8'h01, 1'b0, ADD_WRAP, 8'h10, 1'b0};
    tbl[2] = '{8'hFF, 8'h00, 1'b1, ADD_WRAP, 8'h00, 1'b1};
    tbl[3] = '{8'h80, 8'h80, 1'b0, ADD_WRAP, 8'h00, 1'b1};
    tbl[4] = '{8'hC0, 8'h50, 1'b0, ADD_SAT,  8'hFF, 1'b1};
    tbl[5] = '{8'h7F, 8'h00, 1'b1, ADD_SAT,  8'h80, 1'b0};
    tbl[6] = '{8'hFF, 8'hFF, 1'b1, ADD_WRAP, 8'hFF, 1'b1};
    tbl[7] = '{8'h81, 8'h80, 1'b0, ADD_WRAP, 8'h01, 1'b1};
    tbl[8] = '{8'h12, 8'h34, 1'b0, ADD_SAT,  8'h46, 1'b0};
    tbl[9] = '{8'h00, 8'h00, 1'b0, ADD_SAT,  8'h00, 1'b0};

    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid_s[i] = 1'b0; out_ready_s[i] = 1'b0;
      a_s[i] = '0; b_s[i] = '0; cin_s[i] = 1'b0; mode_s[i] = ADD_WRAP;
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check("rst_out_valid", {31'd0, out_valid_s[i]}, 32'd0);
      check("rst_sum", {16'd0, sum_s[i]}, 32'd0);
      check("rst_carry", {31'd0, carry_s[i]}, 32'd0);
      check("rst_in_ready", {31'd0, in_ready_s[i]}, 32'd1);
    end
    for (int i = 0; i < 3; i++) out_ready_s[i] = 1'b1;

    // Single beats from the table: latency, value, then output held through a bubble.
    for (int v = 0; v < 10; v++) begin
      @(posedge clk); #1;
      in_valid_s[0] = 1'b1;
      a_s[0] = {8'h00, tbl[v].a}; b_s[0] = {8'h00, tbl[v].b};
      cin_s[0] = tbl[v].cin; mode_s[0] = tbl[v].mode;
      @(negedge clk);
      check("tbl_accept", {31'd0, in_ready_s[0]}, 32'd1);
      sample(0);
      wait_result(0, 2);
      check("tbl_sum", {16'd0, sum_s[0]}, {24'd0, tbl[v].exp_sum});
      check("tbl_carry", {31'd0, carry_s[0]}, {31'd0, tbl[v].exp_carry});
      sample(0);
      @(posedge clk); #1;
      a_s[0] = 16'($urandom); b_s[0] = 16'($urandom);
      @(negedge clk);
      check("bubble_valid", {31'd0, out_valid_s[0]}, 32'd0);
      check("bubble_hold", {16'd0, sum_s[0]}, {24'd0, tbl[v].exp_sum});
    end

    // Six back-to-back beats with the consumer stalled in cycles 3..5.
    retired = 0; exp_q.delete(); hold_pend = 1'b0; sent = 0;
    for (int i = 0; i < 6; i++) begin
      bp_a[i] = 8'($urandom); bp_b[i] = 8'($urandom);
    end
    for (int c = 0; c < 20 && retired < 6; c++) begin
      @(posedge clk); #1;
      in_valid_s[0] = (sent < 6);
      if (sent < 6) begin
        a_s[0] = {8'h00, bp_a[sent]}; b_s[0] = {8'h00, bp_b[sent]};
        cin_s[0] = sent[0]; mode_s[0] = (sent == 2) ? ADD_SAT : ADD_WRAP;
      end
      out_ready_s[0] = !(c >= 3 && c <= 5);
      @(negedge clk);
      check("bp_in_ready", {31'd0, in_ready_s[0]}, (c >= 3 && c <= 5) ? 32'd0 : 32'd1);
      if (in_valid_s[0] && in_ready_s[0]) sent++;
      sample(0);
    end
    check("bp_count", retired, 6);
    in_valid_s[0] = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      sample(0);
    end

    // Reset with two beats in flight; neither may ever emerge.
    exp_q.delete(); hold_pend = 1'b0; out_ready_s[0] = 1'b0; retired = 0;
    @(posedge clk); #1;
    in_valid_s[0] = 1'b1; a_s[0] = 16'h0011; b_s[0] = 16'h0022; cin_s[0] = 1'b0; mode_s[0] = ADD_WRAP;
    @(negedge clk);
    check("rst_flight0", {31'd0, in_ready_s[0]}, 32'd1);
    @(posedge clk); #1;
    a_s[0] = 16'h0033; b_s[0] = 16'h0044;
    @(negedge clk);
    check("rst_flight1", {31'd0, in_ready_s[0]}, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0; in_valid_s[0] = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; out_ready_s[0] = 1'b1;
    in_valid_s[0] = 1'b1; a_s[0] = 16'h005A; b_s[0] = 16'h000C; cin_s[0] = 1'b1; mode_s[0] = ADD_WRAP;
    @(negedge clk);
    check("midrst_valid", {31'd0, out_valid_s[0]}, 32'd0);
    check("midrst_sum", {16'd0, sum_s[0]}, 32'd0);
    check("midrst_carry", {31'd0, carry_s[0]}, 32'd0);
    check("midrst_in_ready", {31'd0, in_ready_s[0]}, 32'd1);
    sample(0);
    wait_result(0, 2);
    check("midrst_new_sum", {16'd0, sum_s[0]}, 32'h67);
    sample(0);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      sample(0);
    end
    check("midrst_count", retired, 1);

    verbose = 1'b0;
    run_random(0, 2000);
    run_random(1, 10000);
    run_random(2, 10000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
